rep_add_mul_ctrl: RTL and testbench

- Control and accumulate stage of the repeated-addition multiplier.
- Consumes the count value from the B (multiplier) down-count register and drives that register's loadb/dcb strobes.
- Holds the multiplicand and adds it into a double-width accumulator once per decrement until the count reaches zero.
- Sits between the operand inputs and the product output. The B register is a separate block; this block wraps around it.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_acc_reg.sv | 23 ++
 rtl/rep_add_mul_ctrl.sv | 95 +++++++++
 tb/tb_rep_add_mul_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier control slice.
package mul_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/mul_acc_reg.sv
// Product accumulator: synchronous clear, add-enable, otherwise hold.
module mul_acc_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             add_en,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/rep_add_mul_ctrl.sv
// Control and accumulate stage of the repeated-addition multiplier; drives the
// external B down-count register and sums the multiplicand once per decrement.
//
//   state | meaning
//   IDLE  | waiting for start, product holds last result
//   LOAD  | load B register, capture multiplicand, clear accumulator
//   RUN   | decrement B and add multiplicand until b_count reaches zero
//   DONE  | one-cycle done pulse, product holds
module rep_add_mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int PWIDTH = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  data_a,
    input  logic [WIDTH-1:0]  b_count,
    output logic              loadb,
    output logic              dcb,
    output logic [PWIDTH-1:0] product,
    output logic              busy,
    output logic              done
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic             acc_clear;
    logic             acc_add;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
        end else if (state == S_LOAD) begin
            a_reg <= data_a;
        end
    end

    always_comb begin
        state_next = state;
        loadb      = 1'b0;
        dcb        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        acc_clear  = 1'b0;
        acc_add    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                loadb      = 1'b1;
                busy       = 1'b1;
                acc_clear  = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (b_count == '0) begin
                    state_next = S_DONE;
                end else begin
                    dcb     = 1'b1;
                    acc_add = 1'b1;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    mul_acc_reg #(
        .WIDTH (PWIDTH)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (acc_clear),
        .add_en (acc_add),
        .addend ({{(PWIDTH - WIDTH){1'b0}}, a_reg}),
        .acc    (product)
    );

endmodule

// File: tb/tb_rep_add_mul_ctrl.sv
// Directed bench for rep_add_mul_ctrl with a behavioural B down-count register.
module tb_rep_add_mul_ctrl;
    import mul_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [15:0] b_count;
    logic        loadb;
    logic        dcb;
    logic [31:0] product;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    rep_add_mul_ctrl #(.WIDTH(16), .PWIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_a  (data_a),
        .b_count (b_count),
        .loadb   (loadb),
        .dcb     (dcb),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // B register model: not reset by rst_n, reloaded on loadb, decremented on dcb.
    initial b_count = 16'd0;
    always @(posedge clk) begin
        if (loadb)    b_count <= data_b;
        else if (dcb) b_count <= b_count - 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start pulse at edge 0, then track strobes until done or budget expires.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_prod);
        int edges;
        int dcb_cnt;
        int loadb_cnt;
        data_a = a;
        data_b = b;
        start  = 1'b1;
        step();
        start     = 1'b0;
        edges     = 0;
        dcb_cnt   = 0;
        loadb_cnt = loadb ? 1 : 0;
        chk({tag, "_busy_load"}, {31'd0, busy}, 32'd1);
        while (!done && edges < 70000) begin
            step();
            edges++;
            if (dcb)   dcb_cnt++;
            if (loadb) loadb_cnt++;
        end
        chk({tag, "_done_edge"}, edges, {16'd0, b} + 32'd2);
        chk({tag, "_dcb_cnt"}, dcb_cnt, {16'd0, b});
        chk({tag, "_loadb_cnt"}, loadb_cnt, 32'd1);
        chk({tag, "_product"}, product, exp_prod);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        step();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, product, exp_prod);
    endtask

    initial begin
        int dones;
        rst_n  = 1'b0;
        start  = 1'b0;
        data_a = '0;
        data_b = '0;
        #12;
        chk("rst_product", product, 32'd0);
        chk("rst_ctl", {27'd0, loadb, dcb, busy, done, 1'b0}, 32'd0);
        chk("rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("idle_start0", {30'd0, dut.state}, {30'd0, ST_IDLE});

        run_mul("basic", 16'd3, 16'd5, 32'h0000_000F);
        run_mul("bzero", 16'h1234, 16'd0, 32'd0);
        run_mul("azero", 16'd0, 16'd4, 32'd0);

        // Start re-pulsed during RUN with data_a changed: ignored.
        data_a = 16'd2;
        data_b = 16'd3;
        start  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start  = 1'b1;
        data_a = 16'd9;
        step();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dones++;
            step();
        end
        chk("busy_start_dones", dones, 32'd1);
        chk("busy_start_product", product, 32'd6);

        // start held high: new LOAD on the first IDLE cycle after DONE.
        data_a = 16'd5;
        data_b = 16'd1;
        start  = 1'b1;
        step();
        step();
        step();
        step();
        chk("held_done", {31'd0, done}, 32'd1);
        step();
        chk("held_idle", {30'd0, dut.state}, {30'd0, ST_IDLE});
        step();
        chk("held_reload", {31'd0, loadb}, 32'd1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("held_product", product, 32'd5);

        // Reset asserted during the 4th RUN cycle.
        data_a = 16'd7;
        data_b = 16'd10;
        start  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("midrun_pre", product, 32'd21);
        rst_n = 1'b0;
        #1;
        chk("midrun_product", product, 32'd0);
        chk("midrun_ctl", {28'd0, loadb, dcb, busy, done}, 32'd0);
        chk("midrun_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        step();
        rst_n = 1'b1;
        step();
        run_mul("after_rst", 16'd7, 16'd2, 32'd14);

        run_mul("max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
